con_fsm: RTL
============

// Module: con_fsm
// PURPOSE
//  Multi-cycle control unit for the module computer; the next generation after the one-shot combinational decoder.
//  Sequences FETCH/EXEC with memory and IO ready handshakes, width-parametrised IR/register fields.
//  Adds JZ, HALT-to-stop, illegal-opcode flag and a retired-instruction counter. Drives datapath strobes directly.
// PARAMETERS
//  DATA_W  8   IR / data width; must satisfy OPC_W + 2*REG_AW <= DATA_W
//  OPC_W   4   opcode field width, ir[DATA_W-1 -: OPC_W]
//  REG_AW  2   register address width; reg_sr=ir[REG_AW-1:0], reg_dr=ir[2*REG_AW-1:REG_AW]
//  CNT_W   16  retired-instruction counter width
// PORTS
//  clk      in   1       single clock, rising edge
//  rst_n    in   1       asynchronous active-low reset
//  run      in   1       start request, sampled only in START
//  ir       in   DATA_W  instruction register contents
//  g, z     in   1,1     greater / zero flags from flag register
//  mem_rdy  in   1       memory completes the current ram_re/ram_wr this cycle
//  in_vld   in   1       input port has data
//  out_rdy  in   1       output port accepts data
//  ir_ld, ram_re, ram_wr, pc_ld, pc_inc, reg_we  out 1  datapath strobes
//  reg_sr, reg_dr  out REG_AW  register file source / dest
//  s        out  2       address mux: 00 PC, 01 MOVC source, 10 MOVB dest
//  au_en    out  1       ALU output enable;  au_ac out OPC_W  ALU opcode = opcode field
//  gf_en, mux_s, in_en, out_en  out 1  flag load, reg-write mux, IO strobes (in_en=in_rdy, out_en=out_vld)
//  halted   out  1       in HALT state
//  ill      out  1       sticky: an undefined opcode has executed
//  icount   out  CNT_W   retired instructions, wraps modulo 2^CNT_W
//  state    out  2       START=00 FETCH=01 EXEC=10 HALT=11
// BEHAVIOUR
//  - state/ill/icount registered; strobes combinational from state, ir, handshake inputs
//  - reset (async, immediate): state=START, ill=0, icount=0; all strobes 0 in START and HALT
//  - START: -> FETCH when run=1; otherwise stay. run ignored outside START
//  - FETCH: ram_re=1, s=00; on mem_rdy: ir_ld=1, pc_inc=1, -> EXEC; no mem_rdy: hold, no other strobes
//  - EXEC by opcode (0 MOVA,1 MOVB,2 MOVC,3 MOVD,4 ADD,5 SUB,6 JMP,7 JG,8 IN,9 OUT,A MOVI,B JZ,F HALT):
//    MOVA/ADD/SUB: au_en, mux_s, reg_we 1 cycle; SUB also gf_en. MOVD: reg_we only
//    MOVB: s=10, au_en, ram_wr held until mem_rdy. MOVC: s=01, ram_re held; reg_we, mux_s only in mem_rdy cycle
//    MOVI: s=00, ram_re held; on mem_rdy reg_we, mux_s, pc_inc (skip immediate)
//    IN: in_en held; reg_we, mux_s only in in_vld cycle. OUT: au_en, out_en held until out_rdy
//    JMP: pc_ld. JG: pc_ld=g. JZ: pc_ld=z (flags sampled in EXEC cycle)
//    HALT: -> HALT, not counted. C/D/E: NOP, ill<=1, counted
//  - instruction completes when its wait (if any) ends: icount+1, -> FETCH
//  - zero-wait (ready inputs tied 1): 2 cycles per instruction
//  - HALT: halted=1, stays until rst_n low
//  - at most one of ram_re/ram_wr per cycle; pc_ld and pc_inc never together
//  - icount at 2^CNT_W-1 wraps to 0 on next retire
// STRUCTURE
//  - con_pkg: opcode localparams, state encodings, s-mux codes
//  - sub-module con_op_dec: opcode -> one-hot instruction lines (combinational); FSM, counter and ill in con_fsm
// TESTING
//  1 reset while held in MOVB wait -> all strobes 0 at once, state=00, icount=0; run=1 -> FETCH next edge
//  2 zero-wait program ADD r1,r2; SUB; HALT -> 2 cycles/instr, gf_en 1 cycle on SUB, halted=1, icount=2
//  3 MOVC with mem_rdy after 3 cycles -> ram_re 4 cycles, s=01, reg_we exactly on 4th cycle
//  4 JG g=0 then g=1; JZ z=1 -> pc_ld 0,1,1; pc_inc never with pc_ld
//  5 IN with in_vld after 5 cycles; OUT with out_rdy=0 for 2 -> hold strobes, single reg_we, then FETCH
//  6 opcode D -> ill=1 sticky; CNT_W=4 run 17 NOPs -> icount=1 (wrapped)

Source files
------------

// File: rtl/con_pkg.sv
// con_pkg: shared state encodings, opcode values, address-mux codes and decoded-op bundle
package con_pkg;
   typedef enum logic [1:0] {
      ST_START = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10,
      ST_HALT  = 2'b11
   } state_t;
   localparam int OP_MOVA = 0;
   localparam int OP_MOVB = 1;
   localparam int OP_MOVC = 2;
   localparam int OP_MOVD = 3;
   localparam int OP_ADD  = 4;
   localparam int OP_SUB  = 5;
   localparam int OP_JMP  = 6;
   localparam int OP_JG   = 7;
   localparam int OP_IN   = 8;
   localparam int OP_OUT  = 9;
   localparam int OP_MOVI = 10;
   localparam int OP_JZ   = 11;
   localparam int OP_HALT = 15;
   localparam logic [1:0] S_PC   = 2'b00;
   localparam logic [1:0] S_MOVC = 2'b01;
   localparam logic [1:0] S_MOVB = 2'b10;
   typedef struct packed {
      logic mova, movb, movc, movd, add, sub, jmp, jg, inp, outp, movi, jz, hlt, ill;
   } op_t;
endpackage

// File: rtl/con_op_dec.sv
// con_op_dec: opcode field to one-hot instruction lines; anything unlisted is illegal
module con_op_dec
   import con_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opc,
   output op_t              op
);
   // one compare per defined opcode, illegal when none matched
   always_comb begin
      op.mova = opc == OPC_W'(OP_MOVA);
      op.movb = opc == OPC_W'(OP_MOVB);
      op.movc = opc == OPC_W'(OP_MOVC);
      op.movd = opc == OPC_W'(OP_MOVD);
      op.add  = opc == OPC_W'(OP_ADD);
      op.sub  = opc == OPC_W'(OP_SUB);
      op.jmp  = opc == OPC_W'(OP_JMP);
      op.jg   = opc == OPC_W'(OP_JG);
      op.inp  = opc == OPC_W'(OP_IN);
      op.outp = opc == OPC_W'(OP_OUT);
      op.movi = opc == OPC_W'(OP_MOVI);
      op.jz   = opc == OPC_W'(OP_JZ);
      op.hlt  = opc == OPC_W'(OP_HALT);
      op.ill  = !(op.mova | op.movb | op.movc | op.movd | op.add | op.sub | op.jmp |
                  op.jg | op.inp | op.outp | op.movi | op.jz | op.hlt);
   end
endmodule

// File: rtl/con_fsm.sv
// con_fsm: multi-cycle FETCH/EXEC control unit with ready handshakes, illegal flag and retire counter
module con_fsm
   import con_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OPC_W  = 4,
   parameter int REG_AW = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [DATA_W-1:0] ir,
   input  logic              g,
   input  logic              z,
   input  logic              mem_rdy,
   input  logic              in_vld,
   input  logic              out_rdy,
   output logic              ir_ld,
   output logic              ram_re,
   output logic              ram_wr,
   output logic              pc_ld,
   output logic              pc_inc,
   output logic              reg_we,
   output logic [REG_AW-1:0] reg_sr,
   output logic [REG_AW-1:0] reg_dr,
   output logic [1:0]        s,
   output logic              au_en,
   output logic [OPC_W-1:0]  au_ac,
   output logic              gf_en,
   output logic              mux_s,
   output logic              in_en,
   output logic              out_en,
   output logic              halted,
   output logic              ill,
   output logic [CNT_W-1:0]  icount,
   output logic [1:0]        state
);
   state_t           st;
   op_t              op;
   logic [OPC_W-1:0] opc;
   logic             fetch, exec, done, mem_op, wb_ok;

   assign opc   = ir[DATA_W-1 -: OPC_W];
   assign state = st;

   con_op_dec #(.OPC_W(OPC_W)) u_dec (.opc(opc), .op(op));

   // strobes decoded from state, opcode and the handshake that ends the current wait
   always_comb begin
      fetch  = st == ST_FETCH;
      exec   = st == ST_EXEC;
      mem_op = op.movb | op.movc | op.movi;
      done   = mem_op ? mem_rdy : op.inp ? in_vld : op.outp ? out_rdy : 1'b1;
      wb_ok  = op.mova | op.add | op.sub | ((op.movc | op.movi) & mem_rdy) | (op.inp & in_vld);
      ir_ld  = fetch & mem_rdy;
      ram_re = fetch | (exec & (op.movc | op.movi));
      ram_wr = exec & op.movb;
      pc_ld  = exec & (op.jmp | (op.jg & g) | (op.jz & z));
      pc_inc = mem_rdy & (fetch | (exec & op.movi));
      reg_we = exec & (wb_ok | op.movd);
      mux_s  = exec & wb_ok;
      au_en  = exec & (op.mova | op.add | op.sub | op.movb | op.outp);
      gf_en  = exec & op.sub;
      in_en  = exec & op.inp;
      out_en = exec & op.outp;
      s      = !exec ? S_PC : op.movb ? S_MOVB : op.movc ? S_MOVC : S_PC;
      au_ac  = exec ? opc : '0;
      reg_sr = exec ? ir[REG_AW-1:0] : '0;
      reg_dr = exec ? ir[2*REG_AW-1:REG_AW] : '0;
      halted = st == ST_HALT;
   end

   // sequencer: an instruction retires when its wait ends; HALT is terminal and not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= ST_START;
         ill    <= 1'b0;
         icount <= '0;
      end else begin
         case (st)
            ST_START: if (run) st <= ST_FETCH;
            ST_FETCH: if (mem_rdy) st <= ST_EXEC;
            ST_EXEC:
               if (op.hlt) st <= ST_HALT;
               else if (done) begin
                  st     <= ST_FETCH;
                  icount <= icount + 1'b1;
                  ill    <= ill | op.ill;
               end
            ST_HALT: st <= ST_HALT;
         endcase
      end
   end
endmodule
